// File: rtl/cplx_dot_product_engine_pkg.sv
// cplx_dot_product_engine_pkg: shared FSM encoding and width helpers for the complex dot-product engine
package cplx_dot_product_engine_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_e;
  // DRAIN covers the product stage, the accumulate stage and the result-file write edge
  localparam int DRAIN_CYCLES = 3;
  // products are 2*w, their pairwise sum adds one bit, LEN additions add clog2(len) more
  function automatic int acc_width(input int width, input int len);
    return 2 * width + 1 + $clog2(len);
  endfunction
endpackage

// File: rtl/cplx_dot_product_engine_cmac_conj_lane.sv
// cplx_dot_product_engine_cmac_conj_lane: three-stage a*conj(x) multiply-accumulate for one channel
//   clk, rst (async, active-low); clr zeroes the accumulator; en marks an accepted sample
//   a_re/a_im reference sample, x_re/x_im channel sample; acc_re/acc_im running sums
module cplx_dot_product_engine_cmac_conj_lane
  import cplx_dot_product_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = acc_width(16, 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] x_re,
  input  logic signed [WIDTH-1:0] x_im,
  output logic signed [ACC_W-1:0] acc_re,
  output logic signed [ACC_W-1:0] acc_im
);
  localparam int PW = 2 * WIDTH;
  logic signed [WIDTH-1:0] a_re_q, a_re_d, a_im_q, a_im_d, x_re_q, x_re_d, x_im_q, x_im_d;
  logic signed [PW-1:0]    p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ir_q, p_ir_d, p_ri_q, p_ri_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  always_comb begin
    a_re_d   = en ? a_re : a_re_q;
    a_im_d   = en ? a_im : a_im_q;
    x_re_d   = en ? x_re : x_re_q;
    x_im_d   = en ? x_im : x_im_q;
    v1_d     = en;
    p_rr_d   = PW'(a_re_q) * PW'(x_re_q);
    p_ii_d   = PW'(a_im_q) * PW'(x_im_q);
    p_ir_d   = PW'(a_im_q) * PW'(x_re_q);
    p_ri_d   = PW'(a_re_q) * PW'(x_im_q);
    v2_d     = v1_q;
    // a * conj(x) = (ar*xr + ai*xi) + j(ai*xr - ar*xi)
    acc_re_d = clr ? '0 : v2_q ? acc_re_q + ACC_W'(p_rr_q) + ACC_W'(p_ii_q) : acc_re_q;
    acc_im_d = clr ? '0 : v2_q ? acc_im_q + ACC_W'(p_ir_q) - ACC_W'(p_ri_q) : acc_im_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_re_q   <= '0;
      a_im_q   <= '0;
      x_re_q   <= '0;
      x_im_q   <= '0;
      v1_q     <= 1'b0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ir_q   <= '0;
      p_ri_q   <= '0;
      v2_q     <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else begin
      a_re_q   <= a_re_d;
      a_im_q   <= a_im_d;
      x_re_q   <= x_re_d;
      x_im_q   <= x_im_d;
      v1_q     <= v1_d;
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ir_q   <= p_ir_d;
      p_ri_q   <= p_ri_d;
      v2_q     <= v2_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
    end
  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;
endmodule

// File: rtl/cplx_dot_product_engine.sv
// cplx_dot_product_engine: streams LEN samples on NCH channels, r_k = sum a*conj(x_k), scaled/saturated into a result file
//   clk, rst (async, active-low); start pulse begins a run when idle
//   in_valid/in_real/in_imag: one sample per channel, channel k at [k*WIDTH +: WIDTH]
//   readAddr selects r[readAddr] onto registered outReal/outImag (0 when out of range)
//   busy during a run, done pulses after the result file is written, sat flags clipping in the last run
module cplx_dot_product_engine
  import cplx_dot_product_engine_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NCH        = 4,
  parameter int LEN        = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [NCH*WIDTH-1:0]  in_real,
  input  logic [NCH*WIDTH-1:0]  in_imag,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [OUT_WIDTH-1:0]  outReal,
  output logic [OUT_WIDTH-1:0]  outImag,
  output logic                  busy,
  output logic                  done,
  output logic                  sat
);
  localparam int ACC_W = acc_width(WIDTH, LEN);
  localparam int CNT_W = $clog2(LEN + 1);
  // compare in a width that holds both the accumulator and the output range
  localparam int EW = ACC_W > OUT_WIDTH ? ACC_W : OUT_WIDTH;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             drain_q, drain_d;
  logic                   done_q, done_d, sat_q, sat_d;
  logic [OUT_WIDTH-1:0]   res_re_q [NCH], res_re_d [NCH], res_im_q [NCH], res_im_d [NCH];
  logic [OUT_WIDTH-1:0]   out_re_q, out_re_d, out_im_q, out_im_d;
  logic [OUT_WIDTH-1:0]   clip_re [NCH], clip_im [NCH];
  logic [NCH-1:0]         clip_hit;
  logic signed [ACC_W-1:0] acc_re [NCH], acc_im [NCH];
  logic                   accept, clr;
  assign accept = in_valid && state_q == ST_ACCUM;
  assign clr    = start && state_q == ST_IDLE;
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    logic signed [EW-1:0] ext_re, ext_im;
    cplx_dot_product_engine_cmac_conj_lane #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .en    (accept),
      .a_re  (in_real[0 +: WIDTH]),
      .a_im  (in_imag[0 +: WIDTH]),
      .x_re  (in_real[k*WIDTH +: WIDTH]),
      .x_im  (in_imag[k*WIDTH +: WIDTH]),
      .acc_re(acc_re[k]),
      .acc_im(acc_im[k])
    );
    assign ext_re      = EW'(acc_re[k] >>> SHIFT);
    assign ext_im      = EW'(acc_im[k] >>> SHIFT);
    assign clip_re[k]  = ext_re > MAXV ? MAXV[OUT_WIDTH-1:0] : ext_re < MINV ? MINV[OUT_WIDTH-1:0] : ext_re[OUT_WIDTH-1:0];
    assign clip_im[k]  = ext_im > MAXV ? MAXV[OUT_WIDTH-1:0] : ext_im < MINV ? MINV[OUT_WIDTH-1:0] : ext_im[OUT_WIDTH-1:0];
    assign clip_hit[k] = ext_re > MAXV || ext_re < MINV || ext_im > MAXV || ext_im < MINV;
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    sat_d    = sat_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    out_re_d = '0;
    out_im_d = '0;
    case (state_q)
      ST_IDLE:
        if (start) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      ST_ACCUM:
        if (in_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN - 1)) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        // accumulators settle two edges after the last sample; commit on the third
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          sat_d    = |clip_hit;
          res_re_d = clip_re;
          res_im_d = clip_im;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    for (int i = 0; i < NCH; i++)
      if (readAddr == ADDR_WIDTH'(i)) begin
        out_re_d = res_re_q[i];
        out_im_d = res_im_q[i];
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
      res_re_q <= '{default: '0};
      res_im_q <= '{default: '0};
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      sat_q    <= sat_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  assign outReal = out_re_q;
  assign outImag = out_im_q;
  assign busy    = state_q != ST_IDLE;
  assign done    = done_q;
  assign sat     = sat_q;
endmodule
